vga_point_plotter: RTL and testbench

VGA_POINT_PLOTTER -- requirements
Module: vga_point_plotter

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_timing.sv | 60 ++++++
 rtl/vga_point_plotter.sv | 152 +++++++++++++++
 tb/tb_vga_point_plotter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA types and default 640x480@60 timing; horizontal values are in 50 MHz clocks
// (two clocks per pixel), vertical values are in lines.
package vga_pkg;
    localparam int H_ACTIVE_DEF = 1280;
    localparam int H_FRONT_DEF  = 32;
    localparam int H_SYNC_DEF   = 192;
    localparam int H_BACK_DEF   = 96;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    typedef logic [23:0] color_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
        color_t     color;
    } point_t;
endpackage

// File: rtl/vga_timing.sv
// Raster counters and combinational sync/active decode; consumers register these.
module vga_timing
    import vga_pkg::*;
#(
    parameter int HACTIVE      = H_ACTIVE_DEF,
    parameter int HFRONT_PORCH = H_FRONT_DEF,
    parameter int HSYNC        = H_SYNC_DEF,
    parameter int HBACK_PORCH  = H_BACK_DEF,
    parameter int VACTIVE      = V_ACTIVE_DEF,
    parameter int VFRONT_PORCH = V_FRONT_DEF,
    parameter int VSYNC        = V_SYNC_DEF,
    parameter int VBACK_PORCH  = V_BACK_DEF
) (
    input  logic                clk50,
    input  logic                reset,
    output logic [HCOUNT_W-1:0] hcount,
    output logic [VCOUNT_W-1:0] vcount,
    output logic                active,
    output logic                hs_n,
    output logic                vs_n
);
    localparam int HTOTAL   = HACTIVE + HFRONT_PORCH + HSYNC + HBACK_PORCH;
    localparam int VTOTAL   = VACTIVE + VFRONT_PORCH + VSYNC + VBACK_PORCH;
    localparam int HS_START = HACTIVE + HFRONT_PORCH;
    localparam int VS_START = VACTIVE + VFRONT_PORCH;

    logic [HCOUNT_W-1:0] hcount_reg, hcount_next;
    logic [VCOUNT_W-1:0] vcount_reg, vcount_next;

    always_comb begin
        hcount_next = hcount_reg + 1'b1;
        vcount_next = vcount_reg;
        if (hcount_reg == HCOUNT_W'(HTOTAL - 1)) begin
            hcount_next = '0;
            if (vcount_reg == VCOUNT_W'(VTOTAL - 1)) begin
                vcount_next = '0;
            end else begin
                vcount_next = vcount_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            hcount_reg <= '0;
            vcount_reg <= '0;
        end else begin
            hcount_reg <= hcount_next;
            vcount_reg <= vcount_next;
        end
    end

    assign hcount = hcount_reg;
    assign vcount = vcount_reg;
    assign active = (hcount_reg < HCOUNT_W'(HACTIVE)) && (vcount_reg < VCOUNT_W'(VACTIVE));
    assign hs_n   = !((hcount_reg >= HCOUNT_W'(HS_START)) &&
                      (hcount_reg <  HCOUNT_W'(HS_START + HSYNC)));
    assign vs_n   = !((vcount_reg >= VCOUNT_W'(VS_START)) &&
                      (vcount_reg <  VCOUNT_W'(VS_START + VSYNC)));
endmodule

// File: rtl/vga_point_plotter.sv
// Draws up to NUM_POINTS square dots over a background; point updates go to a shadow set
// that is copied to the displayed set once per frame at the start of vertical blanking.
module vga_point_plotter
    import vga_pkg::*;
#(
    parameter int          NUM_POINTS   = 4,
    parameter int          DOT_R        = 0,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter int          HACTIVE      = H_ACTIVE_DEF,
    parameter int          HFRONT_PORCH = H_FRONT_DEF,
    parameter int          HSYNC        = H_SYNC_DEF,
    parameter int          HBACK_PORCH  = H_BACK_DEF,
    parameter int          VACTIVE      = V_ACTIVE_DEF,
    parameter int          VFRONT_PORCH = V_FRONT_DEF,
    parameter int          VSYNC        = V_SYNC_DEF,
    parameter int          VBACK_PORCH  = V_BACK_DEF
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_idx,
    input  logic [9:0]  wr_x,
    input  logic [9:0]  wr_y,
    input  logic        wr_en,
    input  logic [23:0] wr_color,
    output logic        frame_done,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_n,
    output logic        VGA_SYNC_n
);
    localparam logic signed [11:0] DOT_R_S = 12'(DOT_R);

    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic                active;
    logic                hs_n;
    logic                vs_n;

    vga_timing #(
        .HACTIVE      (HACTIVE),
        .HFRONT_PORCH (HFRONT_PORCH),
        .HSYNC        (HSYNC),
        .HBACK_PORCH  (HBACK_PORCH),
        .VACTIVE      (VACTIVE),
        .VFRONT_PORCH (VFRONT_PORCH),
        .VSYNC        (VSYNC),
        .VBACK_PORCH  (VBACK_PORCH)
    ) u_timing (
        .clk50  (clk50),
        .reset  (reset),
        .hcount (hcount),
        .vcount (vcount),
        .active (active),
        .hs_n   (hs_n),
        .vs_n   (vs_n)
    );

    // Holding off writes on the commit cycle keeps every write wholly in one frame.
    logic commit;
    logic wr_fire;
    assign commit     = !reset && (hcount == '0) && (vcount == VCOUNT_W'(VACTIVE));
    assign wr_ready   = !reset && !commit;
    assign frame_done = commit;
    assign wr_fire    = wr_valid && wr_ready;

    point_t wr_point;
    assign wr_point = '{x: wr_x, y: wr_y, en: wr_en, color: wr_color};

    logic [9:0] col;
    logic [9:0] row;
    assign col = hcount[10:1];
    assign row = vcount;

    logic [NUM_POINTS-1:0] hit;
    color_t                dot_color [NUM_POINTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_POINTS; gi++) begin : g_point
            point_t            shadow_reg;
            point_t            active_reg;
            logic signed [11:0] dx;
            logic signed [11:0] dy;

            // Out-of-range indices match no entry, so such writes are accepted and dropped.
            always_ff @(posedge clk50) begin
                if (reset) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    if (wr_fire && (wr_idx == 4'(gi))) begin
                        shadow_reg <= wr_point;
                    end
                    if (commit) begin
                        active_reg <= shadow_reg;
                    end
                end
            end

            assign dx = $signed({2'b00, col}) - $signed({2'b00, active_reg.x});
            assign dy = $signed({2'b00, row}) - $signed({2'b00, active_reg.y});
            assign hit[gi] = active_reg.en &&
                             (dx <= DOT_R_S) && (dx >= -DOT_R_S) &&
                             (dy <= DOT_R_S) && (dy >= -DOT_R_S);
            assign dot_color[gi] = active_reg.color;
        end
    endgenerate

    color_t pix_color;
    always_comb begin
        pix_color = BG_COLOR;
        for (int i = NUM_POINTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pix_color = dot_color[i];
            end
        end
    end

    color_t color_reg;
    logic   hs_reg;
    logic   vs_reg;
    logic   blank_n_reg;

    always_ff @(posedge clk50) begin
        if (reset) begin
            color_reg   <= '0;
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
            blank_n_reg <= 1'b0;
        end else begin
            color_reg   <= active ? pix_color : '0;
            hs_reg      <= hs_n;
            vs_reg      <= vs_n;
            blank_n_reg <= active;
        end
    end

    assign VGA_R       = color_reg[23:16];
    assign VGA_G       = color_reg[15:8];
    assign VGA_B       = color_reg[7:0];
    assign VGA_HS      = hs_reg;
    assign VGA_VS      = vs_reg;
    assign VGA_BLANK_n = blank_n_reg;
    assign VGA_CLK     = hcount[0];
    assign VGA_SYNC_n  = 1'b1;
endmodule

// File: tb/tb_vga_point_plotter.sv
// Bench for vga_point_plotter on a shrunken raster (20x12 pixels, DOT_R=1): per-cycle
// scoreboard against a behavioural model, plus table-driven probes and directed sequences.
module tb_vga_point_plotter;
    localparam int H_ACT = 40;
    localparam int H_FP  = 4;
    localparam int H_SW  = 8;
    localparam int H_BP  = 4;
    localparam int V_ACT = 12;
    localparam int V_FP  = 2;
    localparam int V_SW  = 2;
    localparam int V_BP  = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int NP    = 4;
    localparam int DR    = 1;
    localparam logic [23:0] BG = 24'h102030;

    logic        clk50 = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_idx;
    logic [9:0]  wr_x;
    logic [9:0]  wr_y;
    logic        wr_en;
    logic [23:0] wr_color;
    logic        frame_done;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

    vga_point_plotter #(
        .NUM_POINTS(NP), .DOT_R(DR), .BG_COLOR(BG),
        .HACTIVE(H_ACT), .HFRONT_PORCH(H_FP), .HSYNC(H_SW), .HBACK_PORCH(H_BP),
        .VACTIVE(V_ACT), .VFRONT_PORCH(V_FP), .VSYNC(V_SW), .VBACK_PORCH(V_BP)
    ) dut (
        .clk50(clk50), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
        .wr_x(wr_x), .wr_y(wr_y), .wr_en(wr_en), .wr_color(wr_color),
        .frame_done(frame_done),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
    );

    always #5 clk50 = ~clk50;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    int          m_h, m_v;
    bit          model_valid = 1'b0;
    int          sh_x[NP], sh_y[NP], ac_x[NP], ac_y[NP];
    bit          sh_en[NP], ac_en[NP];
    logic [23:0] sh_c[NP], ac_c[NP];

    typedef struct packed {
        int          h;
        int          v;
        logic [26:0] outs;   // {rgb, hs, vs, blank_n}
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [26:0] model_pixel(input int h, input int v);
        logic [23:0] c;
        bit hs, vs;
        int dx, dy;
        hs = !(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SW);
        vs = !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SW);
        if (h >= H_ACT || v >= V_ACT) return {24'h0, hs, vs, 1'b0};
        c = BG;
        for (int i = NP - 1; i >= 0; i--) begin
            dx = h / 2 - ac_x[i];
            dy = v - ac_y[i];
            if (ac_en[i] && dx <= DR && dx >= -DR && dy <= DR && dy >= -DR) c = ac_c[i];
        end
        return {c, hs, vs, 1'b1};
    endfunction

    initial begin
        forever begin
            @(posedge clk50);
            if (reset) begin
                exp_q.push_back('{h: m_h, v: m_v, outs: {24'h0, 3'b110}});
                m_h = 0;
                m_v = 0;
                for (int i = 0; i < NP; i++) begin
                    sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0; sh_c[i] = '0;
                    ac_x[i] = 0; ac_y[i] = 0; ac_en[i] = 0; ac_c[i] = '0;
                end
            end else begin
                exp_q.push_back('{h: m_h, v: m_v, outs: model_pixel(m_h, m_v)});
                if (m_h == 0 && m_v == V_ACT) begin
                    for (int i = 0; i < NP; i++) begin
                        ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_en[i] = sh_en[i]; ac_c[i] = sh_c[i];
                    end
                end else if (wr_valid && int'(wr_idx) < NP) begin
                    sh_x[wr_idx] = int'(wr_x);
                    sh_y[wr_idx] = int'(wr_y);
                    sh_en[wr_idx] = wr_en;
                    sh_c[wr_idx] = wr_color;
                end
                m_h++;
                if (m_h == H_TOT) begin
                    m_h = 0;
                    m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
                end
            end
            model_valid = 1'b1;
        end
    end

    initial begin
        exp_t e;
        logic [3:0] ctl_exp;
        bit cmt;
        forever begin
            @(negedge clk50);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n} !== e.outs) begin
                    errors++;
                    $display("FAIL pixel h=%0d v=%0d: got %h, expected %h", e.h, e.v,
                             {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n}, e.outs);
                end
            end
            if (model_valid) begin
                cmt = !reset && m_h == 0 && m_v == V_ACT;
                ctl_exp = {!reset && !cmt, cmt, m_h[0], 1'b1};
                checks++;
                if ({wr_ready, frame_done, VGA_CLK, VGA_SYNC_n} !== ctl_exp) begin
                    errors++;
                    $display("FAIL control h=%0d v=%0d: got %b, expected %b (ready,done,vclk,sync_n)",
                             m_h, m_v, {wr_ready, frame_done, VGA_CLK, VGA_SYNC_n}, ctl_exp);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_write(input int idx, input int x, input int y, input bit en, input logic [23:0] c);
        bit done;
        done = 1'b0;
        wr_valid = 1'b1; wr_idx = 4'(idx); wr_x = 10'(x); wr_y = 10'(y); wr_en = en; wr_color = c;
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk50);
            if (wr_ready) begin
                done = 1'b1;
                break;
            end
        end
        check("write_handshake", done, 1);
        @(posedge clk50);
        #1 wr_valid = 1'b0;
    endtask

    task automatic wait_commit();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk50);
            if (frame_done) begin
                found = 1'b1;
                break;
            end
        end
        check("commit_wait", found, 1);
    endtask

    task automatic wait_pos(input int h, input int v, output bit found);
        found = 1'b0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk50);
            if (m_h == h && m_v == v) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Colour shown for pixel (col,row) on its next appearance; X on timeout.
    task automatic probe(input int col, input int row, output logic [23:0] got);
        bit found;
        got = 'x;
        wait_pos(2 * col, row, found);
        if (found) begin
            @(posedge clk50);
            #1 got = {VGA_R, VGA_G, VGA_B};
        end
    endtask

    task automatic measure_sync(input bit use_vs, output int low_len, output int period);
        logic prev, cur;
        bit seen_high;
        bit found;
        low_len = 0;
        period = 0;
        found = 1'b0;
        @(negedge clk50);
        prev = use_vs ? VGA_VS : VGA_HS;
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk50);
            cur = use_vs ? VGA_VS : VGA_HS;
            if (prev && !cur) begin
                found = 1'b1;
                break;
            end
            prev = cur;
        end
        if (found) begin
            low_len = 1;
            seen_high = 1'b0;
            for (int n = 0; n < 2 * FRAME; n++) begin
                @(negedge clk50);
                period++;
                cur = use_vs ? VGA_VS : VGA_HS;
                if (cur) seen_high = 1'b1;
                else if (!seen_high) low_len++;
                else break;
            end
        end
    endtask

    typedef struct {
        bit          do_wr;
        int          idx;
        int          x;
        int          y;
        bit          en;
        logic [23:0] color;
        int          pcol;
        int          prow;
        logic [23:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[14];

    // ---------------- main sequence ----------------
    initial begin
        int n, low_len, period, low_cycles;
        bit found, saw_fd;
        logic [23:0] got;

        vecs[0]  = '{1, 0, 5, 3, 1, 24'h00FF00, 5, 3, 24'h00FF00, "dot_center"};
        vecs[1]  = '{0, 0, 0, 0, 0, 24'h0, 6, 4, 24'h00FF00, "dot_corner"};
        vecs[2]  = '{0, 0, 0, 0, 0, 24'h0, 7, 3, BG, "dot_outside_x"};
        vecs[3]  = '{0, 0, 0, 0, 0, 24'h0, 5, 5, BG, "dot_outside_y"};
        vecs[4]  = '{1, 1, 5, 3, 1, 24'h0000FF, 5, 3, 24'h00FF00, "overlap_low_idx_wins"};
        vecs[5]  = '{1, 0, 5, 3, 0, 24'h00FF00, 5, 3, 24'h0000FF, "disabled_idx0"};
        vecs[6]  = '{1, 2, 0, 0, 1, 24'hFF00FF, 0, 0, 24'hFF00FF, "edge_origin"};
        vecs[7]  = '{0, 0, 0, 0, 0, 24'h0, 1, 1, 24'hFF00FF, "edge_origin_diag"};
        vecs[8]  = '{0, 0, 0, 0, 0, 24'h0, 19, 0, BG, "no_wrap_col"};
        vecs[9]  = '{0, 0, 0, 0, 0, 24'h0, 0, 11, BG, "no_wrap_row"};
        vecs[10] = '{1, 3, 19, 11, 1, 24'h123456, 18, 10, 24'h123456, "edge_far_corner"};
        vecs[11] = '{0, 0, 0, 0, 0, 24'h0, 0, 10, BG, "far_no_wrap"};
        vecs[12] = '{1, 9, 12, 7, 1, 24'hFFFFFF, 12, 7, BG, "idx_out_of_range"};
        vecs[13] = '{1, 1, 5, 3, 0, 24'h0000FF, 5, 3, BG, "all_off_at_probe"};

        reset = 1'b1; wr_valid = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_en = 1'b0; wr_color = '0;
        repeat (3) @(posedge clk50);
        @(negedge clk50);
        check("reset_outputs", {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n, wr_ready, frame_done},
              {24'h0, 3'b110, 2'b00});
        @(posedge clk50);
        #1 reset = 1'b0;

        // First commit lands exactly V_ACT lines after release, at hcount 0.
        found = 1'b0;
        for (n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk50);
            if (frame_done) begin
                found = 1'b1;
                break;
            end
        end
        check("first_frame_done_cycles", found ? n : -1, V_ACT * H_TOT);
        check("first_frame_done_hcount_even", VGA_CLK, 0);

        measure_sync(1'b0, low_len, period);
        check("hs_low_clks", low_len, H_SW);
        check("hs_period_clks", period, H_TOT);
        measure_sync(1'b1, low_len, period);
        check("vs_low_clks", low_len, V_SW * H_TOT);
        check("vs_period_clks", period, FRAME);

        foreach (vecs[i]) begin
            if (vecs[i].do_wr) begin
                do_write(vecs[i].idx, vecs[i].x, vecs[i].y, vecs[i].en, vecs[i].color);
                wait_commit();
            end
            probe(vecs[i].pcol, vecs[i].prow, got);
            check(vecs[i].name, got, vecs[i].exp);
            $display("vec %0d %s: probe (%0d,%0d) got %h", i, vecs[i].name, vecs[i].pcol, vecs[i].prow, got);
        end

        // Write presented first on the commit cycle and held until accepted.
        wait_pos(H_TOT - 1, V_ACT - 1, found);
        check("pre_commit_wait", found, 1);
        @(posedge clk50);
        #1;
        wr_valid = 1'b1; wr_idx = 4'd0; wr_x = 10'd8; wr_y = 10'd6; wr_en = 1'b1; wr_color = 24'hABCDEF;
        low_cycles = 0;
        saw_fd = 1'b0;
        for (n = 0; n < 8; n++) begin
            @(negedge clk50);
            if (wr_ready) break;
            low_cycles++;
            if (frame_done) saw_fd = 1'b1;
        end
        @(posedge clk50);
        #1 wr_valid = 1'b0;
        check("hold_ready_low_cycles", low_cycles, 1);
        check("hold_low_on_commit", saw_fd, 1);
        probe(8, 6, got);
        check("held_write_not_next_frame", got, BG);
        probe(8, 6, got);
        check("held_write_frame_after_next", got, 24'hABCDEF);

        // Reset mid-frame with dots committed.
        wait_pos(20, 6, found);
        check("midframe_wait", found, 1);
        @(posedge clk50);
        #1 reset = 1'b1;
        @(posedge clk50);
        #1 reset = 1'b0;
        @(negedge clk50);
        check("midframe_reset_outputs", {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n}, {24'h0, 3'b110});
        check("midframe_reset_hcount0", VGA_CLK, 0);
        probe(0, 0, got);
        check("post_reset_origin", got, BG);
        probe(8, 6, got);
        check("post_reset_dot", got, BG);
        probe(19, 11, got);
        check("post_reset_far", got, BG);
        probe(8, 6, got);
        check("post_reset_after_commit", got, BG);

        repeat (4) @(posedge clk50);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
